// File: rtl/flash_arb_pkg.sv
// Shared types and defaults for the two-port flash read arbiter.
package flash_arb_pkg;

  localparam int DEF_ADDR_W = 23;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef logic [0:0] port_id_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;

  function automatic logic [1:0] port_onehot(input port_id_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/flash_arb_timer.sv
// Watchdog for one flash transaction: counts enabled cycles since clear.
// expired is high on the cycle the count reaches TIMEOUT_CYCLES-1.
module flash_arb_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin share of one flash read port between two start/done requesters.
// Start->flash_start 1 cycle, finish->done 1 cycle; losers simply hold start until their done.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int BE_W           = DEF_BE_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_start,
  input  logic [ADDR_W-1:0] req0_address,
  input  logic [BE_W-1:0]   req0_byteenable,
  output logic              req0_done,
  output logic              req0_error,
  output logic [DATA_W-1:0] req0_data,
  input  logic              req1_start,
  input  logic [ADDR_W-1:0] req1_address,
  input  logic [BE_W-1:0]   req1_byteenable,
  output logic              req1_done,
  output logic              req1_error,
  output logic [DATA_W-1:0] req1_data,
  output logic              flash_start,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  output logic [BE_W-1:0]   flash_byteenable,
  input  logic              flash_finish,
  input  logic [DATA_W-1:0] flash_readdata,
  output logic [1:0]        grant
);

  state_e            state_q, state_d;
  port_id_t          owner_q, owner_d;
  port_id_t          rr_last_q, rr_last_d;
  port_id_t          win;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [1:0]        grant_q, grant_d;
  logic              start_q, start_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              tmr_clr, tmr_en, tmr_expired;

  flash_arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    addr_d    = addr_q;
    be_d      = be_q;
    grant_d   = grant_q;
    start_d   = start_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    data0_d   = data0_q;
    data1_d   = data1_q;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    win       = '0;

    case (state_q)
      ST_IDLE: begin
        // A finish seen while idle belongs to nobody; wait for it to clear.
        if (!flash_finish && (req0_start || req1_start)) begin
          if (req0_start && req1_start) begin
            win = ~rr_last_q;
          end else begin
            win = req1_start;
          end
          owner_d = win;
          addr_d  = win ? req1_address : req0_address;
          be_d    = win ? req1_byteenable : req0_byteenable;
          grant_d = port_onehot(win);
          start_d = 1'b1;
          tmr_clr = 1'b1;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        tmr_en = 1'b1;
        // Finish takes priority over a coincident timeout.
        if (flash_finish || tmr_expired) begin
          start_d = 1'b0;
          grant_d = GRANT_NONE;
          state_d = ST_DONE;
          if (owner_q == 1'b0) begin
            done0_d = 1'b1;
            err0_d  = !flash_finish;
            if (flash_finish) data0_d = flash_readdata;
          end else begin
            done1_d = 1'b1;
            err1_d  = !flash_finish;
            if (flash_finish) data1_d = flash_readdata;
          end
        end
      end

      ST_DONE: begin
        rr_last_d = owner_q;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_last_q <= 1'b1;
      addr_q    <= '0;
      be_q      <= '0;
      grant_q   <= GRANT_NONE;
      start_q   <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      data0_q   <= '0;
      data1_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
    end
  end

  assign flash_start      = start_q;
  assign flash_read       = start_q;
  assign flash_address    = addr_q;
  assign flash_byteenable = be_q;
  assign grant            = grant_q;
  assign req0_done        = done0_q;
  assign req0_error       = err0_q;
  assign req0_data        = data0_q;
  assign req1_done        = done1_q;
  assign req1_error       = err1_q;
  assign req1_data        = data1_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: scripted requesters and flash responder, a
// transaction-level reference checked every cycle, plus directed literal checks.
module tb_flash_read_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_start = 1'b0, req1_start = 1'b0;
  logic [22:0] req0_address = '0, req1_address = '0;
  logic [3:0]  req0_byteenable = '0, req1_byteenable = '0;
  logic        req0_done, req0_error, req1_done, req1_error;
  logic [31:0] req0_data, req1_data;
  logic        flash_start, flash_read;
  logic [22:0] flash_address;
  logic [3:0]  flash_byteenable;
  logic        flash_finish = 1'b0;
  logic [31:0] flash_readdata = '0;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  flash_read_arbiter #(
    .ADDR_W(23), .DATA_W(32), .BE_W(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_start(req0_start), .req0_address(req0_address), .req0_byteenable(req0_byteenable),
    .req0_done(req0_done), .req0_error(req0_error), .req0_data(req0_data),
    .req1_start(req1_start), .req1_address(req1_address), .req1_byteenable(req1_byteenable),
    .req1_done(req1_done), .req1_error(req1_error), .req1_data(req1_data),
    .flash_start(flash_start), .flash_read(flash_read), .flash_address(flash_address),
    .flash_byteenable(flash_byteenable), .flash_finish(flash_finish),
    .flash_readdata(flash_readdata), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Requesters: each port holds start while it has queued addresses, pops on done.
  logic [22:0] a0_q[$];
  logic [22:0] a1_q[$];
  logic [3:0]  be0 = 4'h0, be1 = 4'h0;

  always @(posedge clk) begin
    #1;
    if (req0_done && a0_q.size() > 0) a0_q.delete(0);
    if (req1_done && a1_q.size() > 0) a1_q.delete(0);
    req0_start      = (a0_q.size() > 0);
    req1_start      = (a1_q.size() > 0);
    req0_byteenable = be0;
    req1_byteenable = be1;
    if (a0_q.size() > 0) req0_address = a0_q[0];
    if (a1_q.size() > 0) req1_address = a1_q[0];
  end

  // Flash responder: finish on the (resp_delay+1)th cycle of flash_start; -1 never.
  int          resp_delay = 0;
  bit          resp_auto = 1'b1;
  bit          stale_finish = 1'b0;
  int          k = 0;
  logic [31:0] resp_q[$];

  always @(posedge clk) begin
    #1;
    if (flash_start) k++;
    else k = 0;
    if (!resp_auto) begin
      flash_finish = stale_finish;
    end else if (flash_start && resp_delay >= 0 && k == resp_delay + 1) begin
      flash_finish   = 1'b1;
      flash_readdata = 32'hFFFF_FFFF;
      if (resp_q.size() > 0) begin
        flash_readdata = resp_q[0];
        resp_q.delete(0);
      end
    end else begin
      flash_finish = 1'b0;
    end
  end

  // Grant log: one entry per new ownership.
  logic [1:0] glog[$];
  logic [1:0] grant_prev = 2'b00;
  always @(posedge clk) begin
    #1;
    if (grant != 2'b00 && grant_prev == 2'b00) glog.push_back(grant);
    grant_prev = grant;
  end

  // Reference: one transaction at a time, rotating fairness, age-limited.
  bit          m_busy = 0, m_cool = 0;
  bit          m_done0 = 0, m_done1 = 0, m_err0 = 0, m_err1 = 0;
  int          m_owner = 0, m_last = 1, m_age = 0;
  logic [22:0] m_addr = '0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_data [2] = '{32'h0, 32'h0};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_cool = 0; m_last = 1; m_age = 0;
      m_done0 = 0; m_done1 = 0; m_err0 = 0; m_err1 = 0;
      m_data[0] = '0; m_data[1] = '0;
    end else begin
      m_done0 = 0; m_done1 = 0;
      if (m_busy) begin
        m_age++;
        if (flash_finish || m_age == TMO) begin
          m_busy = 0;
          m_cool = 1;
          if (m_owner == 0) begin m_done0 = 1; m_err0 = !flash_finish; end
          else begin m_done1 = 1; m_err1 = !flash_finish; end
          if (flash_finish) m_data[m_owner] = flash_readdata;
          m_last = m_owner;
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else if (!flash_finish && (req0_start || req1_start)) begin
        if (req0_start && req1_start) m_owner = 1 - m_last;
        else m_owner = req1_start ? 1 : 0;
        m_addr = (m_owner == 1) ? req1_address : req0_address;
        m_be   = (m_owner == 1) ? req1_byteenable : req0_byteenable;
        m_busy = 1;
        m_age  = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("flash_start", 32'(flash_start), 32'(m_busy));
    chk("flash_read", 32'(flash_read), 32'(m_busy));
    chk("grant", 32'(grant), m_busy ? ((m_owner == 0) ? 32'd1 : 32'd2) : 32'd0);
    chk("req0_done", 32'(req0_done), 32'(m_done0));
    chk("req1_done", 32'(req1_done), 32'(m_done1));
    chk("req0_data", req0_data, m_data[0]);
    chk("req1_data", req1_data, m_data[1]);
    if (m_busy) begin
      chk("flash_address", 32'(flash_address), 32'(m_addr));
      chk("flash_byteenable", 32'(flash_byteenable), 32'(m_be));
    end
    if (m_done0) chk("req0_error", 32'(req0_error), 32'(m_err0));
    if (m_done1) chk("req1_error", 32'(req1_error), 32'(m_err1));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_start(input string tag, input int maxc);
    int c = 0;
    while (!flash_start && c < maxc) begin
      step();
      c++;
    end
    chk({tag, "_start_seen"}, 32'(flash_start), 32'd1);
  endtask

  // n counts flash_start cycles after the one the caller is standing on.
  task automatic wait_done(input string tag, input int port, input int maxc, output int n);
    int   c = 0;
    logic seen = 1'b0;
    n = 0;
    while (!seen && c < maxc) begin
      step();
      c++;
      if (flash_start) n++;
      seen = (port == 0) ? req0_done : req1_done;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    int n;
    int base;
    int c;

    #1 reset = 1'b1;
    step();
    step();
    chk("rst_flash_start", 32'(flash_start), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'({req0_done, req1_done}), 32'd0);
    chk("rst_data0", req0_data, 32'd0);
    chk("rst_data1", req1_data, 32'd0);
    reset = 1'b0;
    step();

    // Single read on port 0.
    resp_delay = 3;
    resp_q.push_back(32'hDEADBEEF);
    be0 = 4'hF;
    a0_q.push_back(23'h00010);
    wait_start("single", 10);
    chk("single_addr", 32'(flash_address), 32'h00010);
    chk("single_be", 32'(flash_byteenable), 32'hF);
    chk("single_grant", 32'(grant), 32'd1);
    wait_done("single", 0, 20, n);
    chk("single_start_cycles", n, 32'd3);
    chk("single_data", req0_data, 32'hDEADBEEF);
    chk("single_err", 32'(req0_error), 32'd0);
    chk("single_port1_data", req1_data, 32'd0);
    step();
    step();

    // Tie after reset, port 0 asks twice and stays held.
    pulse_reset();
    resp_delay = 1;
    resp_q.push_back(32'h1111_0001);
    resp_q.push_back(32'h2222_0002);
    resp_q.push_back(32'h3333_0003);
    resp_q.push_back(32'h4444_0004);
    be0 = 4'hF;
    be1 = 4'hC;
    base = glog.size();
    a0_q.push_back(23'h00001);
    a0_q.push_back(23'h00001);
    a1_q.push_back(23'h7FFFF);
    a1_q.push_back(23'h7FFFF);
    c = 0;
    while ((a0_q.size() != 0 || a1_q.size() != 0) && c < 200) begin
      step();
      c++;
    end
    chk("tie_complete", 32'(a0_q.size() + a1_q.size()), 32'd0);
    chk("tie_grant_count", 32'(glog.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < glog.size()) chk("tie_grant_order", 32'(glog[base + i]), 32'(exp_g[i]));
    end
    chk("tie_data0", req0_data, 32'h3333_0003);
    chk("tie_data1", req1_data, 32'h4444_0004);
    step();
    step();

    // Watchdog on port 1.
    resp_delay = -1;
    be1 = 4'h3;
    a1_q.push_back(23'h00ABC);
    wait_start("tmo", 10);
    wait_done("tmo", 1, 20, n);
    chk("tmo_start_cycles", n + 1, 32'd8);
    chk("tmo_err", 32'(req1_error), 32'd1);
    chk("tmo_data_kept", req1_data, 32'h4444_0004);
    step();
    step();

    // Finish on the final allowed cycle.
    resp_delay = 7;
    resp_q.push_back(32'h1234_5678);
    a0_q.push_back(23'h00100);
    wait_start("edge", 10);
    wait_done("edge", 0, 20, n);
    chk("edge_start_cycles", n + 1, 32'd8);
    chk("edge_err", 32'(req0_error), 32'd0);
    chk("edge_data", req0_data, 32'h1234_5678);
    step();
    step();

    // Reset two cycles into a transaction.
    resp_delay = -1;
    a0_q.push_back(23'h02468);
    wait_start("rstmid", 10);
    step();
    reset = 1'b1;
    #1;
    chk("rstmid_flash_start", 32'(flash_start), 32'd0);
    chk("rstmid_grant", 32'(grant), 32'd0);
    chk("rstmid_done", 32'(req0_done), 32'd0);
    step();
    chk("rstmid_hold_done", 32'(req0_done), 32'd0);
    resp_delay = 1;
    resp_q.push_back(32'hCAFE_F00D);
    reset = 1'b0;
    step();
    chk("rstmid_restart", 32'(flash_start), 32'd1);
    chk("rstmid_addr", 32'(flash_address), 32'h02468);
    wait_done("rstmid", 0, 20, n);
    chk("rstmid_data", req0_data, 32'hCAFE_F00D);
    step();
    step();

    // Stale finish blocks the grant until it drops.
    resp_auto = 1'b0;
    stale_finish = 1'b1;
    a0_q.push_back(23'h0F00F);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stale_no_grant", 32'(grant), 32'd0);
    end
    resp_delay = 2;
    resp_q.push_back(32'h0BAD_CAFE);
    stale_finish = 1'b0;
    resp_auto = 1'b1;
    c = 0;
    while (flash_finish && c < 5) begin
      step();
      c++;
    end
    chk("stale_dropped", 32'(flash_finish), 32'd0);
    chk("stale_still_idle", 32'(flash_start), 32'd0);
    step();
    chk("stale_start", 32'(flash_start), 32'd1);
    chk("stale_addr", 32'(flash_address), 32'h0F00F);
    wait_done("stale", 0, 20, n);
    chk("stale_data", req0_data, 32'h0BAD_CAFE);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not reach the end");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
Shares the single flash read port (level start/finish handshake, 23-bit word address, 32-bit readdata) between two requesters: the audio sample address sequencer (port 0) and a secondary reader such as a display or diagnostic fetch (port 1). Each requester runs the same start-until-done handshake it would use against the flash directly. The arbiter uses round-robin grant, latches the winner's address, and drives one flash transaction at a time. It returns the read word to the owner only, and aborts a transaction on a watchdog timeout.

Parameters:
ADDR_W, 23, flash word address width
DATA_W, 32, flash readdata width
BE_W, 4, byteenable width
TIMEOUT_CYCLES, 1024, max cycles in ISSUE before abort (must be >= 2)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state and outputs immediately
req0_start  in  1  port 0 request; level, held until req0_done
req0_address  in  ADDR_W  port 0 word address; sampled at grant
req0_byteenable  in  BE_W  port 0 byte lanes; sampled at grant
req0_done  out  1  one-cycle completion pulse
req0_error  out  1  valid with req0_done; 1 = timed out
req0_data  out  DATA_W  last word returned to port 0
req1_start, req1_address, req1_byteenable, req1_done, req1_error, req1_data: same as port 0, for port 1
flash_start  out  1  flash transaction request, level
flash_read  out  1  equals flash_start
flash_address  out  ADDR_W  latched address of owner
flash_byteenable  out  BE_W  latched byteenable of owner
flash_finish  in  1  flash transaction complete; readdata valid this cycle
flash_readdata  in  DATA_W  flash read word
grant  out  2  one-hot current owner; 00 when idle

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, all outputs 0, rr_last=1 so port 0 wins the first tie, timer 0.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - Does not grant while flash_finish=1, which guards against a stale finish.
  - Otherwise, with exactly one start high: grant it.
  - With both high: grant the port != rr_last.
  - On grant: latch address, byteenable and owner; set grant; clear timer; go to ISSUE.
- ISSUE:
  - flash_start = flash_read = 1; flash_address and flash_byteenable come from the latch.
  - Timer increments each cycle.
  - flash_finish=1: capture flash_readdata into reqN_data of the owner only; go to DONE with error=0.
  - Otherwise, timer == TIMEOUT_CYCLES-1: go to DONE with error=1; reqN_data is unchanged.
  - flash_finish on the timeout cycle counts as success (finish wins).
  - Requester inputs are ignored; changes to the owner's address have no effect.
- DONE:
  - reqN_done=1 for exactly one cycle; reqN_error is valid alongside it.
  - flash_start=0, grant cleared, rr_last=owner; go to IDLE.
- Latency:
  - Start high in IDLE at cycle c -> flash_start high at c+1.
  - flash_finish at cycle f -> flash_start low, done and data valid at f+1 -> IDLE at f+2.
  - Minimum re-issue to the next flash_start is f+3.
- A requester that still holds start in the IDLE cycle after its done is treated as a new request, subject to round-robin. This means a continuously held port alternates with the other port when both are requesting.
- reqN_data holds its value until that port's next successful completion; it is never overwritten by the other port's read.
- Reset mid-transaction: flash_start, grant and done drop asynchronously and the transaction is dropped without a done. Pending requests are re-arbitrated after reset release.
- Addresses are passed through unmodified, with no wrap or range check; address sequencing belongs to the requester.
- Timer width is $clog2(TIMEOUT_CYCLES).

Decomposition:
- Package flash_arb_pkg holds:
  - the state enum (IDLE, ISSUE, DONE);
  - the ADDR_W, DATA_W and BE_W defaults;
  - the port id type (logic [0:0]);
  - the GRANT_NONE constant.
- One natural sub-module, flash_arb_timer: clear, enable and TIMEOUT_CYCLES parameter in; expired out.

Test Plan:
- Single read: req0_start=1, req0_address=23'h00010, be=4'hF; flash_finish with 32'hDEADBEEF 3 cycles after flash_start. Required response:
  - flash_address=23'h00010 and flash_byteenable=4'hF while flash_start=1;
  - req0_done pulse 1 cycle after finish, with req0_data=32'hDEADBEEF and error=0;
  - req1_data remains 0.
- Tie after reset: both starts high, addresses 23'h00001 and 23'h7FFFF, port 0 held continuously. Required response: grant order 01,10,01,10; each port's data matches its own flash response.
- Timeout (TIMEOUT_CYCLES=8): req1_start with flash_finish never asserted. Required response: flash_start high exactly 8 cycles, then req1_done=1 and req1_error=1; req1_data unchanged.
- Finish on timeout boundary (TIMEOUT_CYCLES=8): flash_finish on the 8th ISSUE cycle. Required response: error=0 and data captured.
- Reset mid-ISSUE: assert reset 2 cycles into ISSUE with req0 holding start. Required response:
  - flash_start=0 and grant=00 within the same cycle, with no req0_done;
  - after release, flash_start re-asserts 1 cycle later with the same address.
- Stale finish: flash_finish held high in IDLE while req0_start=1. Required response: no grant until flash_finish drops, then flash_start on the following cycle.
